// File: rtl/swizzle_checker_if.sv
// Beat stream from the bit-reversal swizzle stage into the checker:
// the swizzled word travels alongside the word it should equal.
interface swizzle_checker_if #(
  parameter int WIDTH = 8
);
  // A beat transfers on a clock edge where in_valid && in_ready. The upstream
  // side holds in_valid, in_data and exp_data steady while in_ready is low.
  // in_ready never depends combinationally on in_valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] exp_data;

  modport master (output in_valid, output in_data, output exp_data, input in_ready);
  modport slave  (input in_valid, input in_data, input exp_data, output in_ready);
endinterface

// File: rtl/swizzle_checker.sv
// Checks a run of TEST_SIZE swizzled words against their expected values, one
// cycle after acceptance, and reports beat count, error count and pass/fail.
module swizzle_checker #(
  parameter  int WIDTH         = 8,
  parameter  int TEST_SIZE     = 50,
  parameter  int STOP_ON_ERROR = 1,
  parameter  int ERR_W         = 8,
  localparam int CNT_W         = $clog2(TEST_SIZE + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  swizzle_checker_if.slave in_if,
  output logic [CNT_W-1:0] count,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(TEST_SIZE);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(TEST_SIZE - 1);
  localparam bit               STOP_C = (STOP_ON_ERROR != 0);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] first_q;
  logic [ERR_W-1:0] err_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_q;

  // Compare stage: the beat accepted last cycle and its index in the run.
  logic             cmp_valid_q;
  logic [WIDTH-1:0] cmp_in_q;
  logic [WIDTH-1:0] cmp_exp_q;
  logic [CNT_W-1:0] cmp_idx_q;

  logic cmp_bad;
  logic ready;
  logic accept;
  logic err_sat;

  assign cmp_bad = cmp_valid_q && (cmp_in_q != cmp_exp_q);
  // A pending mismatch blocks intake immediately so the failing beat is the last one counted.
  assign ready   = (state_q == S_RUN) && (count_q < SIZE_C) && !(STOP_C && cmp_bad);
  assign accept  = ready && in_if.in_valid;
  assign err_sat = &err_q;

  assign in_if.in_ready = ready;
  assign count          = count_q;
  assign err_count      = err_q;
  assign first_err_idx  = first_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign dbg_state      = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      first_q     <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_in_q    <= '0;
      cmp_exp_q   <= '0;
      cmp_idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_q     <= S_RUN;
            count_q     <= '0;
            first_q     <= '0;
            err_q       <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_in_q    <= '0;
            cmp_exp_q   <= '0;
            cmp_idx_q   <= '0;
          end
        end
        S_RUN: begin
          cmp_valid_q <= accept;
          if (accept) begin
            cmp_in_q  <= in_if.in_data;
            cmp_exp_q <= in_if.exp_data;
            cmp_idx_q <= count_q;
            count_q   <= count_q + 1'b1;
          end
          if (cmp_bad) begin
            if (!err_sat) begin
              err_q <= err_q + 1'b1;
            end
            // err_q only ever grows within a run, so zero means no earlier mismatch.
            if (err_q == '0) begin
              first_q <= cmp_idx_q;
            end
          end
          if (STOP_C && cmp_bad) begin
            state_q <= S_FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else if (cmp_valid_q && (cmp_idx_q == LAST_C)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fail_q  <= (err_q != '0) || cmp_bad;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swizzle_checker.sv
// Directed bench for swizzle_checker: one stop-on-error instance and one
// count-and-continue instance share the beat stream; sel picks the observed one.
module tb_swizzle_checker;
  localparam int W  = 8;
  localparam int TS = 50;
  localparam int CW = 6;
  localparam int EW = 8;

  logic         clock;
  logic         reset_n;
  logic         start_s;
  logic         start_c;
  logic         v;
  logic [W-1:0] d;
  logic [W-1:0] e;
  bit           sel;
  int           n_cmp;
  int           n_fail;
  int           rdy_edges;
  logic [W-1:0] exp_q[$];

  swizzle_checker_if #(.WIDTH(W)) if_s ();
  swizzle_checker_if #(.WIDTH(W)) if_c ();

  assign if_s.in_valid = v;
  assign if_s.in_data  = d;
  assign if_s.exp_data = e;
  assign if_c.in_valid = v;
  assign if_c.in_data  = d;
  assign if_c.exp_data = e;

  logic [CW-1:0] cnt_s, cnt_c, fei_s, fei_c;
  logic [EW-1:0] err_s, err_c;
  logic          busy_s, busy_c, done_s, done_c, fail_s, fail_c;
  logic [1:0]    st_s, st_c;

  swizzle_checker #(.WIDTH(W), .TEST_SIZE(TS), .STOP_ON_ERROR(1), .ERR_W(EW)) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start_s), .in_if(if_s),
    .count(cnt_s), .err_count(err_s), .first_err_idx(fei_s),
    .busy(busy_s), .done(done_s), .fail(fail_s), .dbg_state(st_s)
  );

  swizzle_checker #(.WIDTH(W), .TEST_SIZE(TS), .STOP_ON_ERROR(0), .ERR_W(EW)) dut_c (
    .clock(clock), .reset_n(reset_n), .start(start_c), .in_if(if_c),
    .count(cnt_c), .err_count(err_c), .first_err_idx(fei_c),
    .busy(busy_c), .done(done_c), .fail(fail_c), .dbg_state(st_c)
  );

  wire          rdy  = sel ? if_c.in_ready : if_s.in_ready;
  wire [CW-1:0] cnt  = sel ? cnt_c  : cnt_s;
  wire [CW-1:0] fei  = sel ? fei_c  : fei_s;
  wire [EW-1:0] err  = sel ? err_c  : err_s;
  wire          busy = sel ? busy_c : busy_s;
  wire          done = sel ? done_c : done_s;
  wire          fail = sel ? fail_c : fail_s;
  wire [1:0]    st   = sel ? st_c   : st_s;

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial rdy_edges = 0;
  always @(posedge clock) if (rdy) rdy_edges <= rdy_edges + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    v = 1'b0; d = '0; e = '0;
    start_s = 1'b0; start_c = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic pulse_start();
    if (sel) start_c = 1'b1; else start_s = 1'b1;
    @(posedge clock); #1;
    start_s = 1'b0; start_c = 1'b0;
  endtask

  task automatic idle(input int n);
    v = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  // Present one beat and return #1 after the edge that accepted it.
  task automatic send_beat(input logic [W-1:0] din, input logic [W-1:0] dexp);
    bit ok;
    bit was_rdy;
    ok = 1'b0;
    v = 1'b1; d = din; e = dexp;
    for (int k = 0; k < 100; k++) begin
      was_rdy = rdy;
      @(posedge clock); #1;
      if (was_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    v = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_beat: beat %0h not accepted within 100 cycles", din);
    end
  endtask

  function automatic logic [W-1:0] word(input int i);
    return W'(i * 37 + 5);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    n_cmp += 9;
    if (cnt_s !== 6'd0)         begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt_s); end
    if (err_s !== 8'd0)         begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_s); end
    if (fei_s !== 6'd0)         begin n_fail++; $display("FAIL reset_first: got %0d want 0", fei_s); end
    if (busy_s !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_s); end
    if (done_s !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b want 0", done_s); end
    if (fail_s !== 1'b0)        begin n_fail++; $display("FAIL reset_fail: got %b want 0", fail_s); end
    if (if_s.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", if_s.in_ready); end
    if (st_s !== 2'd0)          begin n_fail++; $display("FAIL reset_state: got %0d want 0", st_s); end
    if (if_c.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_c: got %b want 0", if_c.in_ready); end
  endtask

  task automatic test_back_to_back();
    int edges0;
    sel = 1'b0;
    do_reset();
    pulse_start();
    n_cmp += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b want 1", busy); end
    if (rdy !== 1'b1)  begin n_fail++; $display("FAIL b2b_ready: got %b want 1", rdy); end
    if (st !== 2'd1)   begin n_fail++; $display("FAIL b2b_state: got %0d want 1", st); end
    edges0 = rdy_edges;
    for (int i = 0; i < TS; i++) begin
      send_beat(word(i), word(i));
      n_cmp++;
      if (cnt !== CW'(i + 1)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, cnt, i + 1); end
    end
    n_cmp += 2;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_early: got %b want 0", done); end
    if (rdy !== 1'b0)  begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", rdy); end
    idle(1);
    n_cmp += 7;
    if (done !== 1'b1)  begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    if (fail !== 1'b0)  begin n_fail++; $display("FAIL b2b_fail: got %b want 0", fail); end
    if (busy !== 1'b0)  begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    if (cnt !== 6'd50)  begin n_fail++; $display("FAIL b2b_final_count: got %0d want 50", cnt); end
    if (err !== 8'd0)   begin n_fail++; $display("FAIL b2b_err: got %0d want 0", err); end
    if (st !== 2'd2)    begin n_fail++; $display("FAIL b2b_state_done: got %0d want 2", st); end
    if (rdy_edges - edges0 !== 50) begin n_fail++; $display("FAIL b2b_ready_cycles: got %0d want 50", rdy_edges - edges0); end
  endtask

  task automatic test_stop_on_error();
    sel = 1'b0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 7; i++) send_beat(word(i), word(i));
    send_beat(8'hA5, 8'hA4);
    n_cmp += 3;
    if (cnt !== 6'd8)  begin n_fail++; $display("FAIL stop_count_at_bad: got %0d want 8", cnt); end
    if (rdy !== 1'b0)  begin n_fail++; $display("FAIL stop_ready_drop: got %b want 0", rdy); end
    if (err !== 8'd0)  begin n_fail++; $display("FAIL stop_err_latency: got %0d want 0", err); end
    v = 1'b1; d = word(8); e = word(8);
    @(posedge clock); #1;
    n_cmp += 6;
    if (fail !== 1'b1) begin n_fail++; $display("FAIL stop_fail: got %b want 1", fail); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done: got %b want 0", done); end
    if (err !== 8'd1)  begin n_fail++; $display("FAIL stop_err: got %0d want 1", err); end
    if (fei !== 6'd7)  begin n_fail++; $display("FAIL stop_first: got %0d want 7", fei); end
    if (st !== 2'd3)   begin n_fail++; $display("FAIL stop_state: got %0d want 3", st); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", busy); end
    repeat (3) begin @(posedge clock); #1; end
    v = 1'b0;
    n_cmp += 3;
    if (cnt !== 6'd8)  begin n_fail++; $display("FAIL stop_count_hold: got %0d want 8", cnt); end
    if (rdy !== 1'b0)  begin n_fail++; $display("FAIL stop_ready_hold: got %b want 0", rdy); end
    if (fail !== 1'b1) begin n_fail++; $display("FAIL stop_fail_hold: got %b want 1", fail); end
  endtask

  task automatic test_count_errors();
    logic [W-1:0] w;
    sel = 1'b1;
    do_reset();
    pulse_start();
    for (int i = 0; i < TS; i++) begin
      w = word(i);
      if (i == 3 || i == 10 || i == 49) send_beat(w ^ 8'h01, w);
      else send_beat(w, w);
      if (i == 4) begin
        n_cmp += 2;
        if (err !== 8'd1) begin n_fail++; $display("FAIL cnt_err_after3: got %0d want 1", err); end
        if (fei !== 6'd3) begin n_fail++; $display("FAIL cnt_first_after3: got %0d want 3", fei); end
      end
      if (i == 11) begin
        n_cmp += 2;
        if (err !== 8'd2) begin n_fail++; $display("FAIL cnt_err_after10: got %0d want 2", err); end
        if (fei !== 6'd3) begin n_fail++; $display("FAIL cnt_first_kept: got %0d want 3", fei); end
      end
    end
    idle(1);
    n_cmp += 6;
    if (err !== 8'd3)  begin n_fail++; $display("FAIL cnt_err: got %0d want 3", err); end
    if (fei !== 6'd3)  begin n_fail++; $display("FAIL cnt_first: got %0d want 3", fei); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL cnt_done: got %b want 1", done); end
    if (fail !== 1'b1) begin n_fail++; $display("FAIL cnt_fail: got %b want 1", fail); end
    if (cnt !== 6'd50) begin n_fail++; $display("FAIL cnt_count: got %0d want 50", cnt); end
    if (st !== 2'd2)   begin n_fail++; $display("FAIL cnt_state: got %0d want 2", st); end
    pulse_start();
    n_cmp += 5;
    if (err !== 8'd0)  begin n_fail++; $display("FAIL cnt_restart_err: got %0d want 0", err); end
    if (fei !== 6'd0)  begin n_fail++; $display("FAIL cnt_restart_first: got %0d want 0", fei); end
    if (cnt !== 6'd0)  begin n_fail++; $display("FAIL cnt_restart_count: got %0d want 0", cnt); end
    if (fail !== 1'b0) begin n_fail++; $display("FAIL cnt_restart_fail: got %b want 0", fail); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL cnt_restart_done: got %b want 0", done); end
  endtask

  task automatic test_random_gaps();
    logic [W-1:0] w;
    int accepted;
    int gap;
    sel = 1'b0;
    do_reset();
    pulse_start();
    exp_q.delete();
    for (int i = 0; i < TS; i++) exp_q.push_back(word(i) ^ 8'h5A);
    accepted = 0;
    while (exp_q.size() > 0) begin
      gap = $urandom_range(0, 1);
      if (gap != 0) begin
        idle(gap);
        n_cmp++;
        if (cnt !== CW'(accepted)) begin n_fail++; $display("FAIL gap_count_idle: got %0d want %0d", cnt, accepted); end
      end
      w = exp_q.pop_front();
      send_beat(w, w);
      accepted++;
      n_cmp++;
      if (cnt !== CW'(accepted)) begin n_fail++; $display("FAIL gap_count: got %0d want %0d", cnt, accepted); end
    end
    idle(1);
    n_cmp += 4;
    if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b want 1", done); end
    if (fail !== 1'b0) begin n_fail++; $display("FAIL gap_fail: got %b want 0", fail); end
    if (err !== 8'd0)  begin n_fail++; $display("FAIL gap_err: got %0d want 0", err); end
    if (cnt !== 6'd50) begin n_fail++; $display("FAIL gap_final_count: got %0d want 50", cnt); end
  endtask

  task automatic test_reset_mid_run();
    sel = 1'b0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 20; i++) send_beat(word(i), word(i));
    v = 1'b1; d = word(20); e = word(20);
    #3 reset_n = 1'b0;
    #1;
    n_cmp += 5;
    if (cnt !== 6'd0)  begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", cnt); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (rdy !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_ready: got %b want 0", rdy); end
    if (st !== 2'd0)   begin n_fail++; $display("FAIL rst_mid_state: got %0d want 0", st); end
    if (err !== 8'd0)  begin n_fail++; $display("FAIL rst_mid_err: got %0d want 0", err); end
    v = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    pulse_start();
    n_cmp++;
    if (cnt !== 6'd0) begin n_fail++; $display("FAIL rst_restart_count: got %0d want 0", cnt); end
    for (int i = 0; i < TS; i++) send_beat(word(i), word(i));
    idle(1);
    n_cmp += 3;
    if (cnt !== 6'd50) begin n_fail++; $display("FAIL rst_run_count: got %0d want 50", cnt); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL rst_run_done: got %b want 1", done); end
    if (err !== 8'd0)  begin n_fail++; $display("FAIL rst_run_err: got %0d want 0", err); end
  endtask

  task automatic test_start_handling();
    sel = 1'b0;
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) send_beat(word(i), word(i));
    start_s = 1'b1;
    send_beat(word(5), word(5));
    start_s = 1'b0;
    n_cmp++;
    if (cnt !== 6'd6) begin n_fail++; $display("FAIL start_in_run_count: got %0d want 6", cnt); end
    for (int i = 6; i < TS; i++) send_beat(word(i), word(i));
    idle(1);
    n_cmp += 2;
    if (cnt !== 6'd50) begin n_fail++; $display("FAIL start_run_count: got %0d want 50", cnt); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL start_run_done: got %b want 1", done); end
    pulse_start();
    n_cmp += 4;
    if (cnt !== 6'd0)  begin n_fail++; $display("FAIL start_done_count: got %0d want 0", cnt); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL start_done_done: got %b want 0", done); end
    if (busy !== 1'b1) begin n_fail++; $display("FAIL start_done_busy: got %b want 1", busy); end
    if (rdy !== 1'b1)  begin n_fail++; $display("FAIL start_done_ready: got %b want 1", rdy); end
    send_beat(word(0), word(0));
    n_cmp++;
    if (cnt !== 6'd1) begin n_fail++; $display("FAIL start_new_run_count: got %0d want 1", cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    sel = 1'b0;
    reset_n = 1'b0;
    v = 1'b0; d = '0; e = '0;
    start_s = 1'b0; start_c = 1'b0;
    test_reset();
    test_back_to_back();
    test_stop_on_error();
    test_count_errors();
    test_random_gaps();
    test_reset_mid_run();
    test_start_handling();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
